// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS control FSM
// State is registered; controls decode combinationally from state and the IR's op/funct fields.
module multicycle_ctrl #(
   parameter int OP_WIDTH   = 6,
   parameter int STATE_BITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [OP_WIDTH-1:0]   op,
   input  logic [OP_WIDTH-1:0]   funct,
   input  logic                  zero,
   output logic [1:0]            npcop,
   output logic                  RegWre,
   output logic [3:0]            aluop,
   output logic                  PCWr,
   output logic                  sel,
   output logic [1:0]            x1,
   output logic                  wren,
   output logic                  IRWr,
   output logic [1:0]            x2,
   output logic [1:0]            extop,
   output logic                  ill,
   output logic                  retire,
   output logic [STATE_BITS-1:0] state
);

   typedef enum logic [STATE_BITS-1:0] {
      S_FETCH  = STATE_BITS'(0),
      S_DECODE = STATE_BITS'(1),
      S_EXEC   = STATE_BITS'(2),
      S_MEM    = STATE_BITS'(3),
      S_WB     = STATE_BITS'(4)
   } state_t;

   localparam logic [OP_WIDTH-1:0] OP_RTYPE = OP_WIDTH'(6'h00);
   localparam logic [OP_WIDTH-1:0] OP_J     = OP_WIDTH'(6'h02);
   localparam logic [OP_WIDTH-1:0] OP_JAL   = OP_WIDTH'(6'h03);
   localparam logic [OP_WIDTH-1:0] OP_BEQ   = OP_WIDTH'(6'h04);
   localparam logic [OP_WIDTH-1:0] OP_ADDIU = OP_WIDTH'(6'h09);
   localparam logic [OP_WIDTH-1:0] OP_ORI   = OP_WIDTH'(6'h0D);
   localparam logic [OP_WIDTH-1:0] OP_LUI   = OP_WIDTH'(6'h0F);
   localparam logic [OP_WIDTH-1:0] OP_LW    = OP_WIDTH'(6'h23);
   localparam logic [OP_WIDTH-1:0] OP_SW    = OP_WIDTH'(6'h2B);

   localparam logic [OP_WIDTH-1:0] FN_JR    = OP_WIDTH'(6'h08);
   localparam logic [OP_WIDTH-1:0] FN_ADD   = OP_WIDTH'(6'h21);
   localparam logic [OP_WIDTH-1:0] FN_SUB   = OP_WIDTH'(6'h23);
   localparam logic [OP_WIDTH-1:0] FN_AND   = OP_WIDTH'(6'h24);
   localparam logic [OP_WIDTH-1:0] FN_OR    = OP_WIDTH'(6'h25);
   localparam logic [OP_WIDTH-1:0] FN_SLT   = OP_WIDTH'(6'h2A);

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_SLT = 4'b0100;

   state_t     r_state;
   state_t     w_next;
   logic       w_rtype;
   logic       w_rfn_ok;
   logic       w_legal;
   logic [3:0] w_rtype_alu;

   assign w_rtype = (op == OP_RTYPE);
   assign state   = r_state;

   always_comb begin
      w_rfn_ok    = 1'b1;
      w_rtype_alu = ALU_ADD;
      case (funct)
         FN_ADD:  w_rtype_alu = ALU_ADD;
         FN_SUB:  w_rtype_alu = ALU_SUB;
         FN_AND:  w_rtype_alu = ALU_AND;
         FN_OR:   w_rtype_alu = ALU_OR;
         FN_SLT:  w_rtype_alu = ALU_SLT;
         FN_JR:   w_rtype_alu = ALU_ADD;
         default: w_rfn_ok    = 1'b0;
      endcase
   end

   always_comb begin
      case (op)
         OP_RTYPE: w_legal = w_rfn_ok;
         OP_J, OP_JAL, OP_BEQ, OP_ADDIU, OP_ORI, OP_LUI, OP_LW, OP_SW: w_legal = 1'b1;
         default:  w_legal = 1'b0;
      endcase
   end

   always_comb begin
      w_next = S_FETCH;
      npcop  = 2'b00;
      RegWre = 1'b0;
      aluop  = ALU_ADD;
      PCWr   = 1'b0;
      sel    = 1'b0;
      x1     = 2'b00;
      wren   = 1'b0;
      IRWr   = 1'b0;
      x2     = 2'b00;
      extop  = 2'b00;
      ill    = 1'b0;
      retire = 1'b0;
      // Reset holds every control at 0 so an abandoned instruction cannot write.
      if (rst) begin
         case (r_state)
            S_FETCH: begin
               IRWr   = 1'b1;
               PCWr   = 1'b1;
               w_next = S_DECODE;
            end
            S_DECODE: begin
               if (!w_legal) begin
                  ill = 1'b1;
               end else if (op == OP_J) begin
                  PCWr   = 1'b1;
                  npcop  = 2'b10;
                  retire = 1'b1;
               end else if (op == OP_JAL) begin
                  PCWr   = 1'b1;
                  npcop  = 2'b10;
                  w_next = S_WB;
               end else if (w_rtype && funct == FN_JR) begin
                  PCWr   = 1'b1;
                  npcop  = 2'b11;
                  retire = 1'b1;
               end else begin
                  w_next = S_EXEC;
               end
            end
            S_EXEC: begin
               if (w_rtype) begin
                  aluop  = w_rtype_alu;
                  w_next = S_WB;
               end else begin
                  case (op)
                     OP_ADDIU: begin sel = 1'b1; extop = 2'b01; w_next = S_WB; end
                     OP_ORI:   begin aluop = ALU_OR; sel = 1'b1; w_next = S_WB; end
                     OP_LUI:   begin aluop = ALU_OR; sel = 1'b1; extop = 2'b10; w_next = S_WB; end
                     OP_LW, OP_SW: begin sel = 1'b1; extop = 2'b01; w_next = S_MEM; end
                     OP_BEQ: begin
                        aluop  = ALU_SUB;
                        extop  = 2'b01;
                        npcop  = 2'b01;
                        PCWr   = zero;
                        retire = 1'b1;
                     end
                     default: w_next = S_FETCH;
                  endcase
               end
            end
            S_MEM: begin
               if (op == OP_SW) begin
                  wren   = 1'b1;
                  retire = 1'b1;
               end else if (op == OP_LW) begin
                  w_next = S_WB;
               end
            end
            S_WB: begin
               RegWre = 1'b1;
               retire = 1'b1;
               if (w_rtype) begin
                  x1 = 2'b01;
               end else if (op == OP_LW) begin
                  x2 = 2'b01;
               end else if (op == OP_JAL) begin
                  x1 = 2'b10;
                  x2 = 2'b10;
               end
            end
            default: w_next = S_FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next;
      end
   end

endmodule
